alu_sequencer: RTL
==================

// Module: alu_sequencer
// PURPOSE
//   Multi-cycle sequencer between the CPU control FSM and the ALU datapath.
//   Starts on en_group and latches alu_func/alu_in_sel/imm at the start.
//   Fetches operand A (rd), then operand B (rs or immediate) over a shared group bus.
//   Runs the op for EXEC_CYCLES, then pulses alu_end back to the control FSM.
// PARAMETERS
//   W            8   datapath width (operands, result)
//   EXEC_CYCLES  1   cycles spent in EXEC, legal 1..15
// PORTS
//   clk         in   1   rising-edge clock
//   rst         in   1   synchronous reset, active-high
//   en_group    in   1   start/hold request from control FSM (level)
//   alu_func    in   3   000 MOVB, 001 ADD, 010 SUB, 011 AND, 100 OR
//   alu_in_sel  in   1   0: B = imm; 1: B = opnd_bus (rs)
//   imm         in   W   immediate operand
//   opnd_bus    in   W   register-group read data, selected by opnd_sel
//   opnd_sel    out  1   0: group drives rd onto opnd_bus; 1: group drives rs
//   busy        out  1   high in LOAD_A, LOAD_B, EXEC, DONE
//   alu_end     out  1   one-cycle completion pulse
//   alu_out     out  W   registered result, held until next DONE
//   carry       out  1   ADD carry-out / SUB borrow; 0 for other ops
//   zero        out  1   alu_out == 0
//   bad_func    out  1   sticky: unsupported alu_func latched; cleared by next legal start
// BEHAVIOUR
//   Reset: state=IDLE, opnd_sel=0, busy=0, alu_end=0, alu_out=0, carry=0, zero=1, bad_func=0.
//   States: IDLE, LOAD_A, LOAD_B, EXEC, DONE, RELEASE.
//   IDLE:    en_group=1 -> LOAD_A; latch func, in_sel, imm.
//   LOAD_A:  opnd_sel=0; A<=opnd_bus at end of cycle -> LOAD_B.
//   LOAD_B:  opnd_sel=1; B<=(in_sel ? opnd_bus : imm_latched).
//            Load exactly EXEC_CYCLES into cnt -> EXEC.
//   EXEC:    decrement cnt each cycle; at cnt==1 register alu_out/carry/zero -> DONE.
//   DONE:    alu_end=1 for exactly one cycle -> RELEASE.
//   RELEASE: wait for en_group==0, then -> IDLE (no back-to-back restart on a held level).
//   Latency: en_group first sampled high at cycle 0 -> alu_end at cycle 3+EXEC_CYCLES.
//   Arithmetic: modulo 2^W.
//     ADD: {carry,out}=A+B.
//     SUB: out=A-B; carry=1 iff A<B.
//     MOVB: out=B.
//     AND/OR: bitwise.
//   Illegal func (101..111): out=0, carry=0, bad_func=1; alu_end still pulses.
//   Abort: en_group falling in LOAD_A/LOAD_B/EXEC -> IDLE next cycle.
//     No alu_end; alu_out/flags keep previous values.
//   Latching: alu_func/imm changes after the start cycle are ignored until the next start.
//   rst has priority over every transition.
//     rst mid-op -> IDLE with reset values; no alu_end that cycle or after.
//   alu_out/carry/zero change only on the EXEC->DONE edge or on reset.
// TESTING
//   1. ADD, W=8, E=1: rd=8'h7F, rs=8'h01, in_sel=1
//      -> alu_end at cycle 4; alu_out=8'h80, carry=0, zero=0.
//   2. ADD wrap: rd=8'hFF, rs=8'h01 -> alu_out=8'h00, carry=1, zero=1.
//   3. SUB borrow with imm: rd=8'h03, imm=8'h05, in_sel=0
//      -> alu_out=8'hFE, carry=1; opnd_sel sequence 0,1 in LOAD_A/LOAD_B.
//   4. E=4, AND rd=8'hF0 rs=8'h3C -> alu_end at cycle 7, alu_out=8'h30.
//      Hold en_group high 3 more cycles -> no second alu_end.
//   5. Abort: drop en_group in EXEC -> IDLE, no alu_end, alu_out unchanged.
//      rst mid-LOAD_B -> reset values next cycle.
//   6. alu_func=3'b110 -> alu_end pulses, alu_out=0, bad_func=1.
//      Next MOVB imm=8'h5A -> alu_out=8'h5A, bad_func=0.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// Group bus between the control FSM (master) and the ALU sequencer (slave):
// start/hold request, operand selection, register-group read data and result/flags.
interface alu_sequencer_if #(
   parameter int W = 8
) ();
   logic         en_group;
   logic [2:0]   alu_func;
   logic         alu_in_sel;
   logic [W-1:0] imm;
   logic [W-1:0] opnd_bus;
   logic         opnd_sel;
   logic         busy;
   logic         alu_end;
   logic [W-1:0] alu_out;
   logic         carry;
   logic         zero;
   logic         bad_func;

   modport master (
      output en_group, alu_func, alu_in_sel, imm, opnd_bus,
      input  opnd_sel, busy, alu_end, alu_out, carry, zero, bad_func
   );

   modport slave (
      input  en_group, alu_func, alu_in_sel, imm, opnd_bus,
      output opnd_sel, busy, alu_end, alu_out, carry, zero, bad_func
   );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU sequencer: fetches A (rd) then B (rs or imm) over the shared
// group bus, runs the op for EXEC_CYCLES and pulses alu_end once per request.
module alu_sequencer #(
   parameter int W           = 8,
   parameter int EXEC_CYCLES = 1
) (
   input logic             clk,
   input logic             rst,
   alu_sequencer_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD_A  = 3'd1,
      LOAD_B  = 3'd2,
      EXEC    = 3'd3,
      DONE    = 3'd4,
      RELEASE = 3'd5
   } state_t;

   state_t       state_r;
   state_t       next_s;
   logic [2:0]   func_r;
   logic         in_sel_r;
   logic [W-1:0] imm_r;
   logic [W-1:0] a_r;
   logic [W-1:0] b_r;
   logic [3:0]   cnt_r;
   logic [W:0]   res_s;
   logic         start_s;

   // Result with carry/borrow in the top bit; illegal codes yield all zeros.
   function automatic logic [W:0] alu_calc(input logic [2:0] f,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
      logic [W:0] r;
      case (f)
         3'b000:  r = {1'b0, b};
         3'b001:  r = {1'b0, a} + {1'b0, b};
         3'b010:  r = {(a < b), a - b};
         3'b011:  r = {1'b0, a & b};
         3'b100:  r = {1'b0, a | b};
         default: r = '0;
      endcase
      return r;
   endfunction

   assign res_s   = alu_calc(func_r, a_r, b_r);
   assign start_s = (state_r == IDLE) && (next_s == LOAD_A);

   // Next-state logic; a dropped en_group aborts any in-flight fetch or execute.
   always_comb begin
      next_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.en_group) next_s = LOAD_A;
            else              next_s = IDLE;
         end
         LOAD_A: begin
            if (!bus.en_group) next_s = IDLE;
            else               next_s = LOAD_B;
         end
         LOAD_B: begin
            if (!bus.en_group) next_s = IDLE;
            else               next_s = EXEC;
         end
         EXEC: begin
            if (!bus.en_group)       next_s = IDLE;
            else if (cnt_r == 4'd1)  next_s = DONE;
            else                     next_s = EXEC;
         end
         DONE: begin
            next_s = RELEASE;
         end
         RELEASE: begin
            if (!bus.en_group) next_s = IDLE;
            else               next_s = RELEASE;
         end
         default: begin
            next_s = IDLE;
         end
      endcase
   end

   // State, operand/result registers and registered outputs (decoded from next state).
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         func_r       <= 3'b000;
         in_sel_r     <= 1'b0;
         imm_r        <= '0;
         a_r          <= '0;
         b_r          <= '0;
         cnt_r        <= 4'd0;
         bus.opnd_sel <= 1'b0;
         bus.busy     <= 1'b0;
         bus.alu_end  <= 1'b0;
         bus.alu_out  <= '0;
         bus.carry    <= 1'b0;
         bus.zero     <= 1'b1;
         bus.bad_func <= 1'b0;
      end else begin
         state_r <= next_s;
         if (start_s) begin
            func_r       <= bus.alu_func;
            in_sel_r     <= bus.alu_in_sel;
            imm_r        <= bus.imm;
            bus.bad_func <= (bus.alu_func > 3'b100);
         end
         if (state_r == LOAD_A) begin
            a_r <= bus.opnd_bus;
         end
         if (state_r == LOAD_B) begin
            b_r   <= in_sel_r ? bus.opnd_bus : imm_r;
            cnt_r <= 4'(EXEC_CYCLES);
         end else if (state_r == EXEC) begin
            cnt_r <= cnt_r - 4'd1;
         end
         if ((state_r == EXEC) && (next_s == DONE)) begin
            bus.alu_out <= res_s[W-1:0];
            bus.carry   <= res_s[W];
            bus.zero    <= (res_s[W-1:0] == '0);
         end
         bus.opnd_sel <= (next_s == LOAD_B);
         bus.busy     <= (next_s == LOAD_A) || (next_s == LOAD_B) ||
                         (next_s == EXEC)   || (next_s == DONE);
         bus.alu_end  <= (next_s == DONE);
      end
   end

endmodule
